arb_req_ctrl: RTL

ARB_REQ_CTRL -- requirements
Module: arb_req_ctrl

---
 rtl/arb_req_ctrl_pkg.sv | 20 ++
 rtl/arb_req_slot.sv | 64 ++++++
 rtl/arb_req_ctrl.sv | 80 ++++++++
 3 files changed

// File: rtl/arb_req_ctrl_pkg.sv
// rtl/arb_req_ctrl_pkg.sv - shared state type and width helper for arb_req_ctrl
package arb_req_ctrl_pkg;

   // Per-source request FSM states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_XFER    = 2'd2,
      ST_RELEASE = 2'd3
   } slotState_e;

   // ceil(log2(n)) with a floor of 1 so two-valued ranges still get one bit
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/arb_req_slot.sv
// rtl/arb_req_slot.sv - one source's request FSM and tenure beat counter
module arb_req_slot
   import arb_req_ctrl_pkg::*;
#(
   parameter int MAX_BEATS = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic srcValid,
   input  logic srcLast,
   input  logic grant,
   input  logic beatOk,     // downstream ready and no grant error this cycle
   output logic srcReady,
   output logic req,
   output logic inXfer,
   output logic isIdle
);

   localparam int               CNT_W   = clog2(MAX_BEATS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

   slotState_e       state;
   logic [CNT_W-1:0] beatCnt;
   logic [CNT_W-1:0] cntNext;
   logic             accept;

   assign inXfer   = (state == ST_XFER);
   assign isIdle   = (state == ST_IDLE);
   assign req      = (state == ST_REQ) || (state == ST_XFER);
   assign srcReady = inXfer & grant & beatOk;
   assign accept   = srcReady & srcValid;
   assign cntNext  = beatCnt + CNT_W'(1);

   // Request / transfer / release sequencing; tenure ends on packet end or beat cap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         beatCnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (srcValid) state <= ST_REQ;
            end
            ST_REQ: begin
               if (grant) begin
                  state   <= ST_XFER;
                  beatCnt <= '0;
               end
            end
            ST_XFER: begin
               if (accept) begin
                  beatCnt <= cntNext;
                  if (srcLast || (cntNext == CNT_MAX)) state <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (!grant) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/arb_req_ctrl.sv
// rtl/arb_req_ctrl.sv - per-source arbiter requester with shared beat output mux
module arb_req_ctrl
   import arb_req_ctrl_pkg::*;
#(
   parameter int REQ_NUM   = 4,
   parameter int DATA_W    = 32,
   parameter int MAX_BEATS = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [REQ_NUM-1:0]          src_valid,
   input  logic [REQ_NUM*DATA_W-1:0]   src_data,
   input  logic [REQ_NUM-1:0]          src_last,
   output logic [REQ_NUM-1:0]          src_ready,
   output logic [REQ_NUM-1:0]          req,
   input  logic [REQ_NUM-1:0]          grant,
   output logic                        out_valid,
   output logic [DATA_W-1:0]           out_data,
   output logic                        out_last,
   output logic [clog2(REQ_NUM)-1:0]   out_src,
   input  logic                        out_ready,
   output logic                        err_grant
);

   localparam int SRC_W = clog2(REQ_NUM);

   logic [REQ_NUM-1:0] xferVec;
   logic [REQ_NUM-1:0] idleVec;
   logic               multiGrant;
   logic               idleGrant;
   logic               errNow;
   logic               beatOk;

   assign multiGrant = (grant & (grant - REQ_NUM'(1))) != '0;
   assign idleGrant  = |(grant & idleVec);
   assign errNow     = multiGrant | idleGrant;
   assign beatOk     = out_ready & ~errNow;

   for (genvar i = 0; i < REQ_NUM; i++) begin : g_slot
      arb_req_slot #(
         .MAX_BEATS (MAX_BEATS)
      ) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .srcValid (src_valid[i]),
         .srcLast  (src_last[i]),
         .grant    (grant[i]),
         .beatOk   (beatOk),
         .srcReady (src_ready[i]),
         .req      (req[i]),
         .inXfer   (xferVec[i]),
         .isIdle   (idleVec[i])
      );
   end

   // Forward the granted, transferring source; nothing passes on a bad grant
   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      out_src   = '0;
      if (!errNow) begin
         for (int i = 0; i < REQ_NUM; i++) begin
            if (grant[i] && xferVec[i] && src_valid[i]) begin
               out_valid = 1'b1;
               out_data  = src_data[i*DATA_W +: DATA_W];
               out_last  = src_last[i];
               out_src   = SRC_W'(i);
            end
         end
      end
   end

   // Sticky grant protocol error, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      err_grant <= 1'b0;
      else if (errNow) err_grant <= 1'b1;
   end

endmodule
